// File: rtl/mux_scan_pkg.sv
// Shared constants and state type for the 16-channel mux scan sequencer.
package mux_scan_pkg;

  localparam int NCH  = 16;  // channels behind the mux
  localparam int SELW = 4;   // select width
  localparam int CNTW = 4;   // settle counter width (SETTLE range 0..15)

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } scan_state_e;

endpackage

// File: rtl/next_chan_find.sv
// Combinational priority finder: lowest enabled channel strictly above cur.
// Passing cur = -1 returns the first enabled channel of the mask.
module next_chan_find
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]    mask,
  input  logic signed [SELW:0] cur,
  output logic [SELW-1:0]   nxt,
  output logic              found
);

  // Walk from the top down so the lowest qualifying channel is the last write.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        nxt   = SELW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 16:1 bit mux: steps mux_sel over enabled channels,
// samples mux_out into a shadow frame and hands the frame downstream.
// Optional feature macro: SCAN_MASK_EN adds the chan_mask port; without it
// all 16 channels are scanned.
//
// Handshake: frame_valid rises with frame_data and both hold steady until a
// cycle where frame_valid && frame_ready; that edge is the transfer.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cont,
`ifdef SCAN_MASK_EN
  input  logic [NCH-1:0]  chan_mask,
`endif
  output logic [SELW-1:0] mux_sel,
  input  logic            mux_out,
  output logic            busy,
  output logic            frame_valid,
  output logic [NCH-1:0]  frame_data,
  input  logic            frame_ready
);

  // After a select change either wait in SETTLE or go straight to SAMPLE.
  localparam scan_state_e STEP_STATE = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'((SETTLE > 0) ? SETTLE - 1 : 0);

  scan_state_e           state;
  logic [NCH-1:0]        mask_q;
  logic [NCH-1:0]        shadow;
  logic [CNTW-1:0]       cnt;
  logic [NCH-1:0]        mask_src;
  logic [NCH-1:0]        find_mask;
  logic signed [SELW:0]  find_cur;
  logic [SELW-1:0]       nxt;
  logic                  found;
  logic                  launch;
  logic                  first_lookup;

`ifdef SCAN_MASK_EN
  assign mask_src = chan_mask;
`else
  assign mask_src = '1;
`endif

  assign busy = (state != ST_IDLE);

  // A scan begins from IDLE on start, or from DONE on a handshake in cont mode.
  assign launch = ((state == ST_IDLE) && start) ||
                  ((state == ST_DONE) && frame_valid && frame_ready && cont);

  // In IDLE/DONE the finder looks for the first channel of the incoming mask;
  // mid-scan it looks above the current select within the latched mask.
  assign first_lookup = (state == ST_IDLE) || (state == ST_DONE);

  // Select finder inputs for first-channel or next-channel lookup.
  always_comb begin
    find_mask = mask_q;
    find_cur  = {1'b0, mux_sel};
    if (first_lookup) begin
      find_mask = mask_src;
      find_cur  = '1;
    end
  end

  next_chan_find u_find (
    .mask  (find_mask),
    .cur   (find_cur),
    .nxt   (nxt),
    .found (found)
  );

  // Scan FSM with registered select and frame outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mux_sel     <= '0;
      mask_q      <= '0;
      shadow      <= '0;
      cnt         <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else if (launch) begin
      mask_q      <= mask_src;
      shadow      <= '0;
      cnt         <= '0;
      frame_valid <= 1'b0;
      if (found) begin
        mux_sel <= nxt;
        state   <= STEP_STATE;
      end else begin
        state   <= ST_DONE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          shadow[mux_sel] <= mux_out;
          if (found) begin
            mux_sel <= nxt;
            state   <= STEP_STATE;
          end else begin
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!frame_valid) begin
            frame_valid <= 1'b1;
            frame_data  <= shadow;
          end else if (frame_ready) begin
            frame_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with SETTLE=0, one with
// SETTLE=2. Build with SCAN_MASK_EN defined to include the mask scenarios.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start2 = 1'b0;
  logic        cont = 1'b0;
  logic        frame_ready = 1'b0;
  logic [15:0] pat = 16'h0000;
  logic [3:0]  sel0, sel2;
  logic        mo0, mo2;
  logic        busy0, busy2;
  logic        fv0, fv2;
  logic [15:0] fd0, fd2;
`ifdef SCAN_MASK_EN
  logic [15:0] chan_mask = 16'hFFFF;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Behavioural 16:1 mux seen by each instance.
  assign mo0 = pat[sel0];
  assign mo2 = pat[sel2];

  mux_scan_ctrl #(.SETTLE(0)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start0),
    .cont        (cont),
`ifdef SCAN_MASK_EN
    .chan_mask   (chan_mask),
`endif
    .mux_sel     (sel0),
    .mux_out     (mo0),
    .busy        (busy0),
    .frame_valid (fv0),
    .frame_data  (fd0),
    .frame_ready (frame_ready)
  );

  mux_scan_ctrl #(.SETTLE(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start2),
    .cont        (1'b0),
`ifdef SCAN_MASK_EN
    .chan_mask   (chan_mask),
`endif
    .mux_sel     (sel2),
    .mux_out     (mo2),
    .busy        (busy2),
    .frame_valid (fv2),
    .frame_data  (fd2),
    .frame_ready (frame_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (sel0 !== 4'd0)  begin n_errors++; $display("FAIL reset_sel0 got %0d exp 0", sel0); end
    n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL reset_busy0 got %b exp 0", busy0); end
    n_checks++; if (fv0 !== 1'b0)   begin n_errors++; $display("FAIL reset_fv0 got %b exp 0", fv0); end
    n_checks++; if (fd0 !== 16'h0)  begin n_errors++; $display("FAIL reset_fd0 got %h exp 0000", fd0); end
    n_checks++; if (sel2 !== 4'd0)  begin n_errors++; $display("FAIL reset_sel2 got %0d exp 0", sel2); end
    n_checks++; if (busy2 !== 1'b0) begin n_errors++; $display("FAIL reset_busy2 got %b exp 0", busy2); end
    n_checks++; if (fv2 !== 1'b0)   begin n_errors++; $display("FAIL reset_fv2 got %b exp 0", fv2); end
    rst_n = 1'b1;
    tick();
  endtask

  // SETTLE=0, full mask: channel j selected right after edge j, valid at 17.
  task automatic test_full_scan();
    int cyc;
    bit seq_ok;
    pat = 16'hA5C3; frame_ready = 1'b1; cont = 1'b0;
    start0 = 1'b1;
    tick();  // edge 0
    start0 = 1'b0;
    cyc = 0;
    seq_ok = (sel0 == 4'd0);
    n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL full_busy got %b exp 1", busy0); end
    while (!fv0 && cyc < 40) begin
      tick();
      cyc++;
      if (cyc <= 15 && sel0 !== 4'(cyc)) seq_ok = 1'b0;
      if (cyc > 15 && sel0 !== 4'd15) seq_ok = 1'b0;
    end
    n_checks++; if (cyc !== 17) begin n_errors++; $display("FAIL full_latency got %0d exp 17", cyc); end
    n_checks++; if (!seq_ok) begin n_errors++; $display("FAIL full_sel_order got bad sequence exp 0..15"); end
    n_checks++; if (fd0 !== 16'hA5C3) begin n_errors++; $display("FAIL full_data got %h exp a5c3", fd0); end
    tick();  // handshake
    n_checks++; if (fv0 !== 1'b0 || busy0 !== 1'b0) begin n_errors++; $display("FAIL full_hs got fv=%b busy=%b exp 0 0", fv0, busy0); end
    n_checks++; if (fd0 !== 16'hA5C3 || sel0 !== 4'd15) begin n_errors++; $display("FAIL full_hold got fd=%h sel=%0d exp a5c3 15", fd0, sel0); end
  endtask

  // SETTLE=2: each select held 3 cycles, valid 49 cycles after start.
  task automatic test_settle();
    int cyc;
    bit hold_ok;
    pat = 16'hA5C3; frame_ready = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0;
    hold_ok = (sel2 == 4'd0);
    while (!fv2 && cyc < 80) begin
      tick();
      cyc++;
      if (cyc <= 47 && sel2 !== 4'(cyc / 3)) hold_ok = 1'b0;
    end
    n_checks++; if (cyc !== 49) begin n_errors++; $display("FAIL settle_latency got %0d exp 49", cyc); end
    n_checks++; if (!hold_ok) begin n_errors++; $display("FAIL settle_hold got bad select timing exp 3 cycles each"); end
    n_checks++; if (fd2 !== 16'hA5C3) begin n_errors++; $display("FAIL settle_data got %h exp a5c3", fd2); end
    tick();
    n_checks++; if (fv2 !== 1'b0 || busy2 !== 1'b0) begin n_errors++; $display("FAIL settle_hs got fv=%b busy=%b exp 0 0", fv2, busy2); end
  endtask

  // Downstream stalls 10 cycles; start held high during the scan is ignored.
  task automatic test_backpressure();
    int cyc;
    bit stable_ok;
    pat = 16'h3C5A; frame_ready = 1'b0; cont = 1'b0;
    start0 = 1'b1;
    tick();
    cyc = 0;
    while (!fv0 && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 5) start0 = 1'b0;
    end
    n_checks++; if (cyc !== 17) begin n_errors++; $display("FAIL bp_latency got %0d exp 17", cyc); end
    n_checks++; if (fd0 !== 16'h3C5A) begin n_errors++; $display("FAIL bp_data got %h exp 3c5a", fd0); end
    pat = 16'hFFFF;
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fv0 !== 1'b1 || fd0 !== 16'h3C5A || sel0 !== 4'd15 || busy0 !== 1'b1) stable_ok = 1'b0;
    end
    n_checks++; if (!stable_ok) begin n_errors++; $display("FAIL bp_stable got change while stalled exp hold fv=1 fd=3c5a sel=15"); end
    frame_ready = 1'b1;
    tick();
    n_checks++; if (fv0 !== 1'b0 || busy0 !== 1'b0) begin n_errors++; $display("FAIL bp_hs got fv=%b busy=%b exp 0 0", fv0, busy0); end
  endtask

  // Continuous mode: second frame starts right after the handshake.
  task automatic test_back_to_back();
    int cyc;
    bit busy_ok;
    pat = 16'h00FF; frame_ready = 1'b1; cont = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 0;
    while (!fv0 && cyc < 40) begin tick(); cyc++; end
    n_checks++; if (fd0 !== 16'h00FF || cyc !== 17) begin n_errors++; $display("FAIL b2b_first got fd=%h cyc=%0d exp 00ff 17", fd0, cyc); end
    pat = 16'hFF00;
    tick();  // handshake, restart
    cont = 1'b0;
    n_checks++; if (busy0 !== 1'b1 || fv0 !== 1'b0 || sel0 !== 4'd0) begin n_errors++; $display("FAIL b2b_restart got busy=%b fv=%b sel=%0d exp 1 0 0", busy0, fv0, sel0); end
    cyc = 0;
    busy_ok = 1'b1;
    while (!fv0 && cyc < 40) begin
      tick();
      cyc++;
      if (busy0 !== 1'b1) busy_ok = 1'b0;
    end
    n_checks++; if (fd0 !== 16'hFF00 || cyc !== 17) begin n_errors++; $display("FAIL b2b_second got fd=%h cyc=%0d exp ff00 17", fd0, cyc); end
    n_checks++; if (!busy_ok) begin n_errors++; $display("FAIL b2b_busy got idle gap exp none"); end
    tick();
    n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL b2b_end got busy=%b exp 0", busy0); end
  endtask

  // Reset at scan cycle 8 aborts; a fresh start yields a complete frame.
  task automatic test_reset_mid();
    int cyc;
    bit no_valid;
    pat = 16'h1234; frame_ready = 1'b1; cont = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    n_checks++; if (sel0 !== 4'd0 || busy0 !== 1'b0 || fv0 !== 1'b0 || fd0 !== 16'h0) begin n_errors++; $display("FAIL midrst_outs got sel=%0d busy=%b fv=%b fd=%h exp 0 0 0 0000", sel0, busy0, fv0, fd0); end
    rst_n = 1'b1;
    no_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fv0 !== 1'b0 || busy0 !== 1'b0) no_valid = 1'b0;
    end
    n_checks++; if (!no_valid) begin n_errors++; $display("FAIL midrst_quiet got activity after reset exp none"); end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 0;
    while (!fv0 && cyc < 40) begin tick(); cyc++; end
    n_checks++; if (fd0 !== 16'h1234 || cyc !== 17) begin n_errors++; $display("FAIL midrst_fresh got fd=%h cyc=%0d exp 1234 17", fd0, cyc); end
    tick();
  endtask

`ifdef SCAN_MASK_EN
  // Sparse and empty masks.
  task automatic test_mask();
    int cyc;
    pat = 16'hFFFF; frame_ready = 1'b1; cont = 1'b0;
    chan_mask = 16'h8001;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chan_mask = 16'h0000;  // mid-scan change must be ignored
    n_checks++; if (sel0 !== 4'd0) begin n_errors++; $display("FAIL mask_sel_a got %0d exp 0", sel0); end
    tick();
    n_checks++; if (sel0 !== 4'd15) begin n_errors++; $display("FAIL mask_sel_b got %0d exp 15", sel0); end
    cyc = 1;
    while (!fv0 && cyc < 40) begin tick(); cyc++; end
    n_checks++; if (fd0 !== 16'h8001 || cyc !== 3) begin n_errors++; $display("FAIL mask_sparse got fd=%h cyc=%0d exp 8001 3", fd0, cyc); end
    tick();
    chan_mask = 16'h0000;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 0;
    while (!fv0 && cyc < 40) begin tick(); cyc++; end
    n_checks++; if (fd0 !== 16'h0000 || cyc !== 1) begin n_errors++; $display("FAIL mask_empty got fd=%h cyc=%0d exp 0000 1", fd0, cyc); end
    tick();
    chan_mask = 16'hFFFF;
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_settle();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
